lcd_display_arbiter: RTL and testbench

- Shares the single 2x16 character LCD driver among NUM_REQ processor-side requesters, for example register-file, PC and ALU-result monitors.
- Each requester presents an 18-bit word. The block sequences the driver's reset, then grants round-robin, one 18-bit binary write at a time.
- The driver has no busy/done output, so completion is timed by cycle counters.
- Sits between the processor debug taps and the LCD driver; both run on the same clk.

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_display_arbiter_if.sv | 15 +
 rtl/rr_priority_pick.sv | 26 ++
 rtl/lcd_display_arbiter.sv | 157 +++++++++++++++
 tb/tb_lcd_display_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and driver timing constants for the LCD display arbiter.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_PULSE = 3'd0,
    ST_INIT_WAIT  = 3'd1,
    ST_IDLE       = 3'd2,
    ST_LOAD       = 3'd3,
    ST_WRITE      = 3'd4,
    ST_RELEASE    = 3'd5
  } lcd_state_e;

  localparam int unsigned LCD_DATA_W         = 18;
  localparam int unsigned LCD_RST_PULSE      = 2;
  localparam int unsigned LCD_DRV_BIT_CYCLES = 4;
  localparam int unsigned LCD_CURSOR_STEPS   = 2;
  localparam int unsigned LCD_MIN_INIT_CYCLES = 16;
  // Driver shifts every data bit plus two cursor steps, each taking BIT_CYCLES.
  localparam int unsigned LCD_MIN_WRITE_CYCLES =
    (LCD_DATA_W + LCD_CURSOR_STEPS) * LCD_DRV_BIT_CYCLES;

endpackage

// File: rtl/lcd_display_arbiter_if.sv
// Requester-side bus of the LCD display arbiter.
interface lcd_display_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 18
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      reinit;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;

  modport master (output req, req_data, reinit, input grant, done, busy);
  modport slave  (input req, req_data, reinit, output grant, done, busy);
endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  int idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req[PTR_W'(idx)]) winner = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/lcd_display_arbiter.sv
// Shares one character-LCD driver among NUM_REQ requesters: driver reset
// sequencing, round-robin grant, fixed-length timed write windows.
module lcd_display_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned INIT_CYCLES  = 24,
  parameter int unsigned WRITE_CYCLES = 96,
  parameter int unsigned DATA_W       = LCD_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_display_arbiter_if.slave  bus,
  output logic                  lcd_rst,
  output logic                  lcd_enable,
  output logic [DATA_W-1:0]     lcd_data
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_CYC = (INIT_CYCLES > WRITE_CYCLES) ? INIT_CYCLES : WRITE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

  if (WRITE_CYCLES < LCD_MIN_WRITE_CYCLES) begin : g_bad_write
    $error("WRITE_CYCLES shorter than the driver write time");
  end
  if (INIT_CYCLES < LCD_MIN_INIT_CYCLES) begin : g_bad_init
    $error("INIT_CYCLES shorter than the driver init time");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W != LCD_DATA_W) begin : g_bad_cfg
    $error("unsupported NUM_REQ or DATA_W");
  end

  lcd_state_e          state, stateNext;
  logic [TMR_W-1:0]    timer, timerNext;
  logic [PTR_W-1:0]    rrPtr, rrPtrNext;
  logic [PTR_W-1:0]    winnerIdx, winnerNext;
  logic                reinitPend, reinitPendNext;
  logic [NUM_REQ-1:0]  grantQ, grantNext;
  logic [NUM_REQ-1:0]  doneQ, doneNext;
  logic                busyQ, busyNext;
  logic                lcdRstNext, enableNext;
  logic [DATA_W-1:0]   dataNext;
  logic [PTR_W-1:0]    pickIdx;
  logic                pickValid;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) uPick (
    .req    (bus.req),
    .ptr    (rrPtr),
    .winner (pickIdx),
    .valid  (pickValid)
  );

  assign bus.grant = grantQ;
  assign bus.done  = doneQ;
  assign bus.busy  = busyQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT_PULSE;
      timer      <= '0;
      rrPtr      <= '0;
      winnerIdx  <= '0;
      reinitPend <= 1'b0;
      grantQ     <= '0;
      doneQ      <= '0;
      busyQ      <= 1'b1;
      lcd_rst    <= 1'b0;
      lcd_enable <= 1'b0;
      lcd_data   <= '0;
    end else begin
      state      <= stateNext;
      timer      <= timerNext;
      rrPtr      <= rrPtrNext;
      winnerIdx  <= winnerNext;
      reinitPend <= reinitPendNext;
      grantQ     <= grantNext;
      doneQ      <= doneNext;
      busyQ      <= busyNext;
      lcd_rst    <= lcdRstNext;
      lcd_enable <= enableNext;
      lcd_data   <= dataNext;
    end
  end

  // Each state's actions land on the edge that ends its cycle.
  always_comb begin
    stateNext      = state;
    timerNext      = timer;
    rrPtrNext      = rrPtr;
    winnerNext     = winnerIdx;
    reinitPendNext = reinitPend;
    grantNext      = grantQ;
    doneNext       = '0;
    lcdRstNext     = 1'b0;
    enableNext     = 1'b0;
    dataNext       = lcd_data;
    unique case (state)
      ST_INIT_PULSE: begin
        if (timer == TMR_W'(LCD_RST_PULSE)) begin
          stateNext = ST_INIT_WAIT;
          timerNext = '0;
        end else begin
          lcdRstNext = 1'b1;
          timerNext  = timer + TMR_W'(1);
        end
      end
      ST_INIT_WAIT: begin
        if (timer == TMR_W'(INIT_CYCLES - 1)) begin
          stateNext = ST_IDLE;
          timerNext = '0;
        end else begin
          timerNext = timer + TMR_W'(1);
        end
      end
      ST_IDLE: begin
        timerNext = '0;
        if (bus.reinit) begin
          stateNext = ST_INIT_PULSE;
        end else if (pickValid) begin
          winnerNext = pickIdx;
          stateNext  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dataNext   = bus.req_data[winnerIdx*DATA_W +: DATA_W];
        grantNext  = NUM_REQ'(1) << winnerIdx;
        enableNext = 1'b1;
        timerNext  = '0;
        stateNext  = ST_WRITE;
        if (bus.reinit) reinitPendNext = 1'b1;
      end
      ST_WRITE: begin
        if (bus.reinit) reinitPendNext = 1'b1;
        if (timer == TMR_W'(WRITE_CYCLES - 1)) begin
          stateNext = ST_RELEASE;
          timerNext = '0;
        end else begin
          timerNext = timer + TMR_W'(1);
        end
      end
      ST_RELEASE: begin
        doneNext       = NUM_REQ'(1) << winnerIdx;
        grantNext      = '0;
        rrPtrNext      = (winnerIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winnerIdx + PTR_W'(1);
        reinitPendNext = 1'b0;
        timerNext      = '0;
        stateNext      = (reinitPend || bus.reinit) ? ST_INIT_PULSE : ST_IDLE;
      end
      default: begin
        stateNext = ST_INIT_PULSE;
        timerNext = '0;
      end
    endcase
    busyNext = (stateNext != ST_IDLE);
  end

endmodule

// File: tb/tb_lcd_display_arbiter.sv
// Directed bench for lcd_display_arbiter: init sequencing, round-robin, data hold,
// reinit handling and asynchronous reset mid-write.
module tb_lcd_display_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lcd_rst, lcd_enable;
  logic [DW-1:0] lcd_data;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  lcd_display_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  lcd_display_arbiter #(.NUM_REQ(NR), .INIT_CYCLES(24), .WRITE_CYCLES(96), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .lcd_rst    (lcd_rst),
    .lcd_enable (lcd_enable),
    .lcd_data   (lcd_data)
  );

  task automatic set_word(input int i, input logic [DW-1:0] w);
    bus.req_data[i*DW +: DW] = w;
  endtask

  // Measures 60 cycles of an init sequence; clears reinit after the first cycle.
  task automatic watch_init(output int rstHigh, output int firstRise, output int idleAt, output int enAt);
    rstHigh = 0; firstRise = -1; idleAt = -1; enAt = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.reinit = 1'b0;
      if (lcd_rst) begin
        rstHigh++;
        if (firstRise < 0) firstRise = n;
      end
      if (!bus.busy && idleAt < 0) idleAt = n;
      if (lcd_enable && enAt < 0) enAt = n;
    end
  endtask

  task automatic wait_done(output int cyc, output logic [NR-1:0] dn);
    cyc = -1; dn = '0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        cyc = n; dn = bus.done;
        break;
      end
    end
  endtask

  task automatic wait_enable(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (lcd_enable) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Follows one write window and reports what it saw.
  task automatic observe_write(output int enCyc, output logic [NR-1:0] g, output logic [DW-1:0] d,
                               output int wlen, output logic [NR-1:0] dn, output logic [NR-1:0] gAtDone,
                               output bit held);
    g = '0; d = '0; wlen = -1; dn = '0; gAtDone = '1; held = 1'b1;
    wait_enable(enCyc);
    if (enCyc >= 0) begin
      g = bus.grant; d = lcd_data;
      for (int n = 1; n <= 300; n++) begin
        @(negedge clk);
        if (bus.done != '0) begin
          wlen = n; dn = bus.done; gAtDone = bus.grant;
          break;
        end
        if (bus.grant !== g || lcd_data !== d) held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int rh, fr, ia, ea;
    rst = 1'b0; bus.req = '0; bus.req_data = '0; bus.reinit = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++; if (bus.busy !== 1'b1) begin nFails++; $display("FAIL reset_busy got %b want 1", bus.busy); end
    nChecks++; if (bus.grant !== 4'b0) begin nFails++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
    nChecks++; if (bus.done !== 4'b0) begin nFails++; $display("FAIL reset_done got %b want 0000", bus.done); end
    nChecks++; if (lcd_enable !== 1'b0) begin nFails++; $display("FAIL reset_enable got %b want 0", lcd_enable); end
    nChecks++; if (lcd_data !== 18'h0) begin nFails++; $display("FAIL reset_data got %h want 0", lcd_data); end
    nChecks++; if (lcd_rst !== 1'b0) begin nFails++; $display("FAIL reset_lcd_rst got %b want 0", lcd_rst); end
    rst = 1'b1;
    watch_init(rh, fr, ia, ea);
    nChecks++; if (rh != 2) begin nFails++; $display("FAIL init_rst_len got %0d want 2", rh); end
    nChecks++; if (fr != 1) begin nFails++; $display("FAIL init_rst_rise got %0d want 1", fr); end
    nChecks++; if (ia != 27) begin nFails++; $display("FAIL init_idle_at got %0d want 27", ia); end
    nChecks++; if (ea != -1) begin nFails++; $display("FAIL init_spurious_enable got %0d want -1", ea); end
    nChecks++; if (bus.grant !== 4'b0) begin nFails++; $display("FAIL init_grant got %b want 0000", bus.grant); end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 3, 0};
    logic [DW-1:0] words [4] = '{18'h11111, 18'h22222, 18'h0, 18'h33333};
    int en, wl; logic [NR-1:0] g, dn, gd, want; logic [DW-1:0] d; bit held;
    for (int i = 0; i < 4; i++) set_word(i, words[i]);
    bus.req = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      observe_write(en, g, d, wl, dn, gd, held);
      want = 4'b0001 << order[i];
      nChecks++; if (en != 2) begin nFails++; $display("FAIL rr_latency[%0d] got %0d want 2", i, en); end
      nChecks++; if (g !== want) begin nFails++; $display("FAIL rr_grant[%0d] got %b want %b", i, g, want); end
      nChecks++; if (d !== words[order[i]]) begin nFails++; $display("FAIL rr_data[%0d] got %h want %h", i, d, words[order[i]]); end
      nChecks++; if (wl != 97) begin nFails++; $display("FAIL rr_window[%0d] got %0d want 97", i, wl); end
      nChecks++; if (dn !== want) begin nFails++; $display("FAIL rr_done[%0d] got %b want %b", i, dn, want); end
      nChecks++; if (!held || gd !== 4'b0) begin nFails++; $display("FAIL rr_hold[%0d] held %0d grant_at_done %b want 1 0000", i, held, gd); end
    end
    bus.req = '0;
  endtask

  task automatic test_single();
    int en, wl; logic [NR-1:0] g, dn, gd; logic [DW-1:0] d; bit held;
    set_word(1, 18'h2A5F3);
    bus.req = 4'b0010;
    observe_write(en, g, d, wl, dn, gd, held);
    bus.req = '0;
    nChecks++; if (en != 2) begin nFails++; $display("FAIL single_latency got %0d want 2", en); end
    nChecks++; if (g !== 4'b0010) begin nFails++; $display("FAIL single_grant got %b want 0010", g); end
    nChecks++; if (d !== 18'h2A5F3) begin nFails++; $display("FAIL single_data got %h want 2a5f3", d); end
    nChecks++; if (wl != 97) begin nFails++; $display("FAIL single_window got %0d want 97", wl); end
    nChecks++; if (dn !== 4'b0010) begin nFails++; $display("FAIL single_done got %b want 0010", dn); end
    nChecks++; if (!held) begin nFails++; $display("FAIL single_hold got 0 want 1"); end
    @(negedge clk);
    nChecks++; if (bus.done !== 4'b0) begin nFails++; $display("FAIL single_done_width got %b want 0000", bus.done); end
  endtask

  task automatic test_data_hold();
    int en, cyc; logic [NR-1:0] dn; bit held;
    set_word(0, 18'h00001);
    bus.req = 4'b0001;
    wait_enable(en);
    nChecks++; if (lcd_data !== 18'h00001) begin nFails++; $display("FAIL hold_load_data got %h want 00001", lcd_data); end
    repeat (10) @(negedge clk);
    set_word(0, 18'h3FFFF);
    held = 1'b1; dn = '0; cyc = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (lcd_data !== 18'h00001) held = 1'b0;
      if (bus.done != '0) begin dn = bus.done; cyc = n; break; end
    end
    bus.req = '0;
    nChecks++; if (!held) begin nFails++; $display("FAIL hold_data_changed got %h want 00001", lcd_data); end
    nChecks++; if (dn !== 4'b0001 || cyc != 87) begin nFails++; $display("FAIL hold_done got %b at %0d want 0001 at 87", dn, cyc); end
    set_word(0, 18'h0);
  endtask

  task automatic test_reinit_write();
    int en, cyc, rh, fr, ia, ea; logic [NR-1:0] dn;
    set_word(2, 18'h0ABCD);
    bus.req = 4'b0100;
    wait_enable(en);
    nChecks++; if (bus.grant !== 4'b0100) begin nFails++; $display("FAIL rwr_grant got %b want 0100", bus.grant); end
    repeat (20) @(negedge clk);
    bus.reinit = 1'b1;
    @(negedge clk);
    bus.reinit = 1'b0;
    wait_done(cyc, dn);
    bus.req = 4'b0001;
    set_word(0, 18'h05555);
    nChecks++; if (dn !== 4'b0100 || cyc != 76) begin nFails++; $display("FAIL rwr_done got %b at %0d want 0100 at 76", dn, cyc); end
    watch_init(rh, fr, ia, ea);
    nChecks++; if (rh != 2 || fr != 1) begin nFails++; $display("FAIL rwr_lcd_rst got len %0d rise %0d want 2 1", rh, fr); end
    nChecks++; if (ia != 27 || ea != 29) begin nFails++; $display("FAIL rwr_next_grant got idle %0d enable %0d want 27 29", ia, ea); end
    nChecks++; if (bus.grant !== 4'b0001 || lcd_data !== 18'h05555) begin nFails++; $display("FAIL rwr_next_word got %b %h want 0001 05555", bus.grant, lcd_data); end
    wait_done(cyc, dn);
    bus.req = '0;
    nChecks++; if (dn !== 4'b0001) begin nFails++; $display("FAIL rwr_next_done got %b want 0001", dn); end
  endtask

  task automatic test_reinit_idle();
    int cyc, rh, fr, ia, ea; logic [NR-1:0] dn;
    set_word(1, 18'h1F0F0);
    bus.req = 4'b0010;
    bus.reinit = 1'b1;
    watch_init(rh, fr, ia, ea);
    nChecks++; if (rh != 2 || fr != 2) begin nFails++; $display("FAIL ridle_lcd_rst got len %0d rise %0d want 2 2", rh, fr); end
    nChecks++; if (ia != 28 || ea != 30) begin nFails++; $display("FAIL ridle_pending got idle %0d enable %0d want 28 30", ia, ea); end
    wait_done(cyc, dn);
    bus.req = '0;
    nChecks++; if (dn !== 4'b0010) begin nFails++; $display("FAIL ridle_done got %b want 0010", dn); end
  endtask

  task automatic test_async_reset();
    int en, cyc, rh, fr, ia, ea; logic [NR-1:0] dn;
    set_word(3, 18'h12345);
    bus.req = 4'b1000;
    wait_enable(en);
    nChecks++; if (bus.grant !== 4'b1000) begin nFails++; $display("FAIL arst_pre_grant got %b want 1000", bus.grant); end
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    nChecks++; if (bus.grant !== 4'b0 || lcd_data !== 18'h0 || lcd_enable !== 1'b0) begin
      nFails++; $display("FAIL arst_outputs got %b %h %b want 0000 00000 0", bus.grant, lcd_data, lcd_enable); end
    nChecks++; if (bus.busy !== 1'b1 || lcd_rst !== 1'b0 || bus.done !== 4'b0) begin
      nFails++; $display("FAIL arst_status got busy %b lcd_rst %b done %b want 1 0 0000", bus.busy, lcd_rst, bus.done); end
    @(negedge clk);
    rst = 1'b1;
    watch_init(rh, fr, ia, ea);
    nChecks++; if (rh != 2 || fr != 1) begin nFails++; $display("FAIL arst_lcd_rst got len %0d rise %0d want 2 1", rh, fr); end
    nChecks++; if (ia != 27 || ea != 29) begin nFails++; $display("FAIL arst_reinit got idle %0d enable %0d want 27 29", ia, ea); end
    nChecks++; if (bus.grant !== 4'b1000 || lcd_data !== 18'h12345) begin nFails++; $display("FAIL arst_regrant got %b %h want 1000 12345", bus.grant, lcd_data); end
    wait_done(cyc, dn);
    bus.req = '0;
    nChecks++; if (dn !== 4'b1000) begin nFails++; $display("FAIL arst_done got %b want 1000", dn); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_data_hold();
    test_reinit_write();
    test_reinit_idle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
